// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB encodings, slave window bases, select/FSM enums and address decode.
package ahb_pkg;
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;
    localparam logic [31:0] ROM_BASE = 32'h0000_0000;
    localparam logic [31:0] RAM_BASE = 32'h2000_0000;
    localparam logic [31:0] PER_BASE = 32'h4000_0000;
    typedef enum logic [2:0] {SEL_NONE, SEL_ROM, SEL_RAM, SEL_PER, SEL_DEF} sel_t;
    typedef enum logic [1:0] {DEF_IDLE, DEF_ERR1, DEF_ERR2} def_state_t;
    // A window matches when every address bit above its width equals the base.
    function automatic sel_t decode(input logic [31:0] addr, input int rom_aw, input int ram_aw, input int per_aw);
        return ((addr >> rom_aw) == (ROM_BASE >> rom_aw)) ? SEL_ROM :
               ((addr >> ram_aw) == (RAM_BASE >> ram_aw)) ? SEL_RAM :
               ((addr >> per_aw) == (PER_BASE >> per_aw)) ? SEL_PER : SEL_DEF;
    endfunction
endpackage

// File: rtl/ahb_default_slave.sv
// ahb_default_slave: answers unmapped transfers; two-cycle ERROR when DEFAULT_SLAVE_ERROR_EN is defined,
// otherwise a permanent OKAY zero-wait responder.
module ahb_default_slave
    import ahb_pkg::*;
(
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic       HSEL,
    input  logic [1:0] HTRANS,
    input  logic       HREADY,
    output logic       HREADYOUT,
    output logic       HRESP
);
`ifdef DEFAULT_SLAVE_ERROR_EN
    def_state_t state, nxt;
    logic active;
    assign active = HSEL && HTRANS[1] && HREADY;
    assign nxt = (state == DEF_ERR1) ? DEF_ERR2 : active ? DEF_ERR1 : DEF_IDLE;
    always_ff @(posedge HCLK or negedge HRESETn)
        if (!HRESETn) begin
            state     <= DEF_IDLE;
            HREADYOUT <= 1'b1;
            HRESP     <= 1'b0;
        end else begin
            state     <= nxt;
            HREADYOUT <= nxt != DEF_ERR1;
            HRESP     <= nxt != DEF_IDLE;
        end
`else
    logic unused;
    assign unused    = ^{HCLK, HRESETn, HSEL, HTRANS, HREADY};
    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;
`endif
endmodule

// File: rtl/ahb_interconnect.sv
// ahb_interconnect: single-master AHB decoder/mux for ROM, RAM, PER and an internal default slave.
// Error responses from the default slave are enabled by DEFAULT_SLAVE_ERROR_EN.
module ahb_interconnect
    import ahb_pkg::*;
#(
    parameter int ROM_AW = 14,
    parameter int RAM_AW = 14,
    parameter int PER_AW = 16
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    output logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HRESP,
    output logic        HSEL_ROM,
    output logic        HSEL_RAM,
    output logic        HSEL_PER,
    input  logic        HREADYOUT_ROM,
    input  logic        HREADYOUT_RAM,
    input  logic        HREADYOUT_PER,
    input  logic [31:0] HRDATA_ROM,
    input  logic [31:0] HRDATA_RAM,
    input  logic [31:0] HRDATA_PER
);
    sel_t sel_d, sel_q;
    logic HREADYOUT_DEF;
    assign sel_d    = decode(HADDR, ROM_AW, RAM_AW, PER_AW);
    assign HSEL_ROM = sel_d == SEL_ROM;
    assign HSEL_RAM = sel_d == SEL_RAM;
    assign HSEL_PER = sel_d == SEL_PER;
    always_ff @(posedge HCLK or negedge HRESETn)
        if (!HRESETn) sel_q <= SEL_NONE;
        else if (HREADY) sel_q <= sel_d;
    // NONE shares the default slave's ready so the bus is free straight out of reset.
    always_comb begin
        HREADY = (sel_q == SEL_ROM) ? HREADYOUT_ROM :
                 (sel_q == SEL_RAM) ? HREADYOUT_RAM :
                 (sel_q == SEL_PER) ? HREADYOUT_PER : HREADYOUT_DEF;
        HRDATA = (sel_q == SEL_ROM) ? HRDATA_ROM :
                 (sel_q == SEL_RAM) ? HRDATA_RAM :
                 (sel_q == SEL_PER) ? HRDATA_PER : 32'h0;
    end
    ahb_default_slave u_def (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HSEL      (sel_d == SEL_DEF),
        .HTRANS    (HTRANS),
        .HREADY    (HREADY),
        .HREADYOUT (HREADYOUT_DEF),
        .HRESP     (HRESP)
    );
endmodule
